// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I datapath: sequences fetch/decode/execute,
// drives every enable and mux select per state, and counts retired instructions.
module multicycle_controller #(
  parameter int CntWidth = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          op,
  input  logic [2:0]          funct3,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                adr_src,
  output logic                mem_write,
  output logic                mem_req,
  output logic                ir_write,
  output logic                reg_write,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          result_src,
  output logic [1:0]          imm_src,
  output logic                illegal,
  output logic [CntWidth-1:0] instret
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_JAL, S_BEQ
  } state_t;

  state_t                state_q, state_d;
  logic [CntWidth-1:0]   instret_q, instret_d;
  logic                  retire;
  logic                  op_legal;

  assign op_legal = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
                    (op == OP_ITYPE) || (op == OP_JAL) || (op == OP_BEQ);
  assign instret  = instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_JAL:            state_d = S_JAL;
          OP_BEQ:            state_d = S_BEQ;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    begin state_d = S_FETCH; retire = 1'b1; end
      S_MEMWRITE: if (mem_ready) begin state_d = S_FETCH; retire = 1'b1; end
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_ALUWB:    begin state_d = S_FETCH; retire = 1'b1; end
      // JAL retires later, at its ALUWB link write
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      begin state_d = S_FETCH; retire = 1'b1; end
      default:    state_d = S_FETCH;
    endcase
    instret_d = instret_q + {{(CntWidth-1){1'b0}}, retire};
  end

  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    mem_req    = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b10;
    alu_op     = 2'b00;
    result_src = 2'b10;
    illegal    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        illegal   = ~op_legal;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        result_src = 2'b00;
        reg_write  = 1'b1;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        result_src = 2'b00;
        pc_write   = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        alu_op     = 2'b01;
        result_src = 2'b00;
        pc_write   = zero && (funct3 == 3'b000);
      end
      default: ;
    endcase
    // strobes must drop the instant reset asserts, not at the next edge
    if (rst) begin
      pc_write  = 1'b0;
      mem_write = 1'b0;
      mem_req   = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  always_comb begin
    unique case (op)
      OP_STORE: imm_src = 2'b01;
      OP_BEQ:   imm_src = 2'b10;
      OP_JAL:   imm_src = 2'b11;
      default:  imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a per-cycle expected control vector
// is queued with each instruction's stimulus and compared as the FSM steps.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic        pc_write, adr_src, mem_write, mem_req, ir_write, reg_write, illegal;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src, imm_src;
  logic [31:0] instret;

  logic        w_pc_write, w_adr_src, w_mem_write, w_mem_req, w_ir_write, w_reg_write, w_illegal;
  logic [1:0]  w_alu_src_a, w_alu_src_b, w_alu_op, w_result_src, w_imm_src;
  logic [2:0]  w_instret;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .mem_req(mem_req),
    .ir_write(ir_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src), .illegal(illegal),
    .instret(instret)
  );

  // narrow-counter twin so wrap-around is reachable in a short run
  multicycle_controller #(.CntWidth(3)) dut_w (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .pc_write(w_pc_write), .adr_src(w_adr_src), .mem_write(w_mem_write), .mem_req(w_mem_req),
    .ir_write(w_ir_write), .reg_write(w_reg_write), .alu_src_a(w_alu_src_a),
    .alu_src_b(w_alu_src_b), .alu_op(w_alu_op), .result_src(w_result_src),
    .imm_src(w_imm_src), .illegal(w_illegal), .instret(w_instret)
  );

  always #5 clk = ~clk;

  wire [16:0] obs   = {pc_write, adr_src, mem_write, mem_req, ir_write, reg_write,
                       alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal};
  wire [16:0] obs_w = {w_pc_write, w_adr_src, w_mem_write, w_mem_req, w_ir_write, w_reg_write,
                       w_alu_src_a, w_alu_src_b, w_alu_op, w_result_src, w_imm_src, w_illegal};

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct {
    logic [16:0] vec;
    logic        mr;
  } step_t;

  step_t       sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_cnt = 32'd0;

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    case (o)
      SW:      return 2'b01;
      BQ:      return 2'b10;
      JL:      return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [16:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic mreq, input logic irw, input logic rw,
                                     input logic [1:0] sa, input logic [1:0] sbs,
                                     input logic [1:0] aop, input logic [1:0] rs,
                                     input logic [1:0] im, input logic ill);
    return {pcw, adr, mw, mreq, irw, rw, sa, sbs, aop, rs, im, ill};
  endfunction

  task automatic push(input logic [16:0] v, input logic mr);
    step_t s;
    s.vec = v;
    s.mr  = mr;
    sb.push_back(s);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected per-cycle outputs of one instruction, written from the state table.
  task automatic plan(input logic [6:0] o, input logic [2:0] f3, input logic z,
                      input int fs, input int ms, output int ret);
    logic [1:0] im;
    logic       legal;
    im    = imm_of(o);
    legal = (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == JL) || (o == BQ);
    for (int i = 0; i < fs; i++) push(mk(0,0,0,1,0,0,2'b00,2'b10,2'b00,2'b10,im,0), 1'b0);
    push(mk(1,0,0,1,1,0,2'b00,2'b10,2'b00,2'b10,im,0), 1'b1);
    push(mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b10,im,!legal), rnd_bit());
    case (o)
      LW: begin
        push(mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b10,im,0), rnd_bit());
        for (int i = 0; i < ms; i++) push(mk(0,1,0,1,0,0,2'b00,2'b10,2'b00,2'b10,im,0), 1'b0);
        push(mk(0,1,0,1,0,0,2'b00,2'b10,2'b00,2'b10,im,0), 1'b1);
        push(mk(0,0,0,0,0,1,2'b00,2'b10,2'b00,2'b01,im,0), rnd_bit());
      end
      SW: begin
        push(mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b10,im,0), rnd_bit());
        for (int i = 0; i < ms; i++) push(mk(0,1,1,1,0,0,2'b00,2'b10,2'b00,2'b10,im,0), 1'b0);
        push(mk(0,1,1,1,0,0,2'b00,2'b10,2'b00,2'b10,im,0), 1'b1);
      end
      RT, IT: begin
        push(mk(0,0,0,0,0,0,2'b10,(o == RT) ? 2'b00 : 2'b01,2'b10,2'b10,im,0), rnd_bit());
        push(mk(0,0,0,0,0,1,2'b00,2'b10,2'b00,2'b00,im,0), rnd_bit());
      end
      JL: begin
        push(mk(1,0,0,0,0,0,2'b01,2'b10,2'b00,2'b00,im,0), rnd_bit());
        push(mk(0,0,0,0,0,1,2'b00,2'b10,2'b00,2'b00,im,0), rnd_bit());
      end
      BQ: push(mk(z && (f3 == 3'b000),0,0,0,0,0,2'b10,2'b00,2'b01,2'b00,im,0), rnd_bit());
      default: ;
    endcase
    ret = legal ? 1 : 0;
  endtask

  task automatic drain(input logic [6:0] o, output int cyc);
    step_t s;
    cyc = 0;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      mem_ready = s.mr;
      @(negedge clk);
      checks++;
      if (obs !== s.vec || obs_w !== s.vec) begin
        errors++;
        $display("FAIL ctrl op=%b cycle=%0d: got %b (narrow %b), want %b",
                 o, cyc + 1, obs, obs_w, s.vec);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic z,
                           input int fs, input int ms);
    int ret, cyc;
    op = o; funct3 = f3; zero = z;
    plan(o, f3, z, fs, ms, ret);
    drain(o, cyc);
    exp_cnt += 32'(ret);
    checks++;
    if (instret !== exp_cnt || w_instret !== exp_cnt[2:0]) begin
      errors++;
      $display("FAIL instret op=%b: got %0d (narrow %0d), want %0d (narrow %0d)",
               o, instret, w_instret, exp_cnt, exp_cnt[2:0]);
    end
    $display("instr op=%b f3=%b zero=%b cycles=%0d instret=%0d", o, f3, z, cyc, instret);
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; op = RT;
    @(posedge clk); #1;
    checks++;
    if (obs !== mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,2'b00,0) || instret !== 32'd0) begin
      errors++;
      $display("FAIL reset: got ctrl=%b instret=%0d, want ctrl=%b instret=0",
               obs, instret, mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,2'b00,0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_wrap();
    checks++;
    if (w_instret !== 3'd0 || instret !== 32'd8) begin
      errors++;
      $display("FAIL wrap: got narrow=%0d wide=%0d, want narrow=0 wide=8", w_instret, instret);
    end
    $display("wrap narrow=%0d wide=%0d", w_instret, instret);
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [6];
    ops = '{LW, SW, RT, IT, JL, BQ};
    for (int i = 0; i < 8; i++)
      run_instr(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 1)), rnd_bit(),
                $urandom_range(0, 2), $urandom_range(0, 2));
  endtask

  task automatic test_async_reset();
    op = SW; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: got mem_write=%b, want 1", mem_write);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({pc_write, mem_write, mem_req, ir_write, reg_write, illegal} !== 6'b0 ||
        instret !== 32'd0 || w_instret !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: got en=%b instret=%0d, want en=000000 instret=0",
               {pc_write, mem_write, mem_req, ir_write, reg_write, illegal}, instret);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 32'd0;
    $display("async reset during store wait");
  endtask

  initial begin
    test_reset();
    run_instr(RT, 3'b000, 1'b0, 0, 0);
    run_instr(LW, 3'b010, 1'b0, 0, 3);
    run_instr(SW, 3'b010, 1'b0, 1, 2);
    run_instr(IT, 3'b000, 1'b0, 0, 0);
    run_instr(BQ, 3'b000, 1'b1, 0, 0);
    run_instr(BQ, 3'b000, 1'b0, 0, 0);
    run_instr(BQ, 3'b001, 1'b1, 0, 0);
    run_instr(JL, 3'b000, 1'b0, 0, 0);
    test_wrap();
    run_instr(BAD, 3'b000, 1'b0, 0, 0);
    test_back_to_back();
    test_async_reset();
    run_instr(RT, 3'b000, 1'b0, 2, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
